// File: rtl/byte_mem_ctrl.sv
// byte_mem_ctrl
//   Bridges the L1 cache's 32-bit request port to a byte-wide synchronous RAM.
//   A read turns into four sequential byte reads (lanes 0..3), each waiting
//   RAM_LATENCY cycles for data. A masked write turns into one byte write per
//   enabled lane, one per cycle. done pulses for one cycle in IDLE, and a new
//   request is accepted in that same cycle.
//
// Ports
//   CLK, RST                 clock (rising edge), async active-low reset
//   rw_flag[1:0]             [0] read, [1] write, 0 idle; read wins on 2'b11
//   addr[31:0]               word address; bits [1:0] and [31:ADDR_WIDTH] unused
//   write_data, write_mask   write word (little-endian lanes) and lane enables
//   read_data[31:0]          assembled read word, held until the next read
//   busy, done               in-progress flag, one-cycle completion pulse
//   ram_addr/re/we/wdata     byte RAM request
//   ram_rdata                byte RAM data, valid RAM_LATENCY cycles after ram_re
module byte_mem_ctrl #(
    parameter int ADDR_WIDTH  = 17,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            rw_flag,
    input  logic [31:0]           addr,
    input  logic [31:0]           write_data,
    input  logic [3:0]            write_mask,
    output logic [31:0]           read_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_re,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [2:0] LAT     = 3'(RAM_LATENCY);

    logic [1:0]            state;
    logic [ADDR_WIDTH-3:0] word_q;   // word part of the latched address
    logic [31:0]           data_q;
    logic [3:0]            mask_q;   // write lanes not yet issued
    logic [1:0]            idx;      // read lane currently awaiting capture
    logic [2:0]            lat;      // cycles left until idx's byte is valid

    logic [2:0]            lat_n;
    logic [1:0]            idx_n;
    logic [1:0]            acc_lane;
    logic [1:0]            wr_lane;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_WIDTH], addr[1:0]};

    function automatic logic [1:0] first_lane(input logic [3:0] m);
        logic [1:0] l;
        casez (m)
            4'b???1: l = 2'd0;
            4'b??10: l = 2'd1;
            4'b?100: l = 2'd2;
            default: l = 2'd3;
        endcase
        return l;
    endfunction

    assign acc_lane = first_lane(write_mask);
    assign wr_lane  = first_lane(mask_q);

    // Read-side lookahead: the strobe for lane k+1 must already be high in the
    // cycle lane k is captured, so ram_re is registered one cycle early from
    // the next-cycle view of (idx, lat).
    always_comb begin
        lat_n = lat - 3'd1;
        idx_n = idx;
        if (lat == 3'd0) begin
            lat_n = LAT - 3'd1;
            idx_n = idx + 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            word_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            idx       <= '0;
            lat       <= '0;
            read_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= '0;
            ram_re    <= 1'b0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            done   <= 1'b0;
            ram_re <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    word_q <= addr[ADDR_WIDTH-1:2];
                    data_q <= write_data;
                    if (rw_flag[0]) begin
                        state    <= S_READ;
                        busy     <= 1'b1;
                        idx      <= 2'd0;
                        lat      <= LAT;
                        ram_re   <= 1'b1;
                        ram_addr <= {addr[ADDR_WIDTH-1:2], 2'd0};
                    end else if (rw_flag[1]) begin
                        if (write_mask == 4'd0) begin
                            done <= 1'b1;  // nothing to write
                        end else begin
                            state     <= S_WRITE;
                            busy      <= 1'b1;
                            mask_q    <= write_mask & ~(4'd1 << acc_lane);
                            ram_we    <= 1'b1;
                            ram_addr  <= {addr[ADDR_WIDTH-1:2], acc_lane};
                            ram_wdata <= write_data[{acc_lane, 3'b000} +: 8];
                        end
                    end
                end
                S_READ: begin
                    if (lat == 3'd0)
                        read_data[{idx, 3'b000} +: 8] <= ram_rdata;
                    if (lat == 3'd0 && idx == 2'd3) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        idx   <= 2'd0;
                    end else begin
                        lat      <= lat_n;
                        idx      <= idx_n;
                        ram_re   <= (lat_n == 3'd0) && (idx_n != 2'd3);
                        ram_addr <= {word_q, idx_n + 2'd1};
                    end
                end
                S_WRITE: begin
                    if (mask_q == 4'd0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        mask_q    <= mask_q & ~(4'd1 << wr_lane);
                        ram_we    <= 1'b1;
                        ram_addr  <= {word_q, wr_lane};
                        ram_wdata <= data_q[{wr_lane, 3'b000} +: 8];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_mem_ctrl.sv
// tb_byte_mem_ctrl
//   Two instances share one clock/reset: g_dut[0] with RAM_LATENCY=1 and
//   g_dut[1] with RAM_LATENCY=3, each with its own byte RAM model. Expected
//   read words go into a scoreboard queue when a request is driven and are
//   popped at the done pulse; RAM strobes are logged per cycle for checking.
module tb_byte_mem_ctrl;
    localparam int AW = 10;

    typedef struct {
        int cyc;
        int a;
        int d;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0][1:0]    rw;
    logic [1:0][31:0]   addr, wdata, rdata;
    logic [1:0][3:0]    mask;
    logic [1:0]         busy, done, re, we;
    logic [1:0][AW-1:0] raddr;
    logic [1:0][7:0]    rwd, rrd;

    logic          pl_en;
    logic [AW-1:0] pl_a;
    logic [7:0]    pl_d;

    int   cyc = 0;
    int   both_cnt = 0;
    int   done_cnt [2] = '{0, 0};
    ev_t  rq[$], wq[$];
    logic [31:0] sbq[$];

    int n_chk = 0, n_fail = 0;
    int c0, rq_base, wq_base;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [7:0] mem  [1024];
        logic [7:0] pipe [L];

        byte_mem_ctrl #(.ADDR_WIDTH(AW), .RAM_LATENCY(L)) u_dut (
            .CLK(clk), .RST(rst_n), .rw_flag(rw[g]), .addr(addr[g]),
            .write_data(wdata[g]), .write_mask(mask[g]), .read_data(rdata[g]),
            .busy(busy[g]), .done(done[g]), .ram_addr(raddr[g]), .ram_re(re[g]),
            .ram_we(we[g]), .ram_wdata(rwd[g]), .ram_rdata(rrd[g])
        );

        // Synchronous byte RAM; filler 8'hEE appears when no read was issued.
        always @(posedge clk) begin
            if (pl_en) mem[pl_a] <= pl_d;
            else if (we[g]) mem[raddr[g]] <= rwd[g];
            pipe[0] <= re[g] ? mem[raddr[g]] : 8'hEE;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign rrd[g] = pipe[L-1];
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (re[g]) rq.push_back('{cyc, int'(raddr[g]), 0});
            if (we[g]) wq.push_back('{cyc, int'(raddr[g]), int'(rwd[g])});
            if (re[g] && we[g]) both_cnt <= both_cnt + 1;
            if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request in the current cycle (cycle 0) and drops rw_flag after it.
    task automatic drive(input int g, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m,
                         input bit is_rd, input logic [31:0] exp_rd);
        rw[g] = f; addr[g] = a; wdata[g] = d; mask[g] = m;
        c0 = cyc; rq_base = rq.size(); wq_base = wq.size();
        if (is_rd) sbq.push_back(exp_rd);
        @(posedge clk); #1 rw[g] = 2'b00;
    endtask

    // Returns at the falling edge of the done cycle.
    task automatic wait_done(input int g, input int exp_dc, input int exp_busy,
                             input bit is_rd, input string tag);
        int dc = -1;
        int n_busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done[g]) begin
                dc = cyc - c0;
                break;
            end
            if (busy[g]) n_busy++;
        end
        chk({tag, "_done_cycle"}, dc, exp_dc);
        chk({tag, "_busy_cycles"}, n_busy, exp_busy);
        chk({tag, "_busy_at_done"}, 32'(busy[g]), 0);
        if (is_rd) chk({tag, "_read_data"}, rdata[g], sbq.pop_front());
    endtask

    task automatic chk_rd_log(input string tag, input int l, input int a0);
        chk({tag, "_n_re"}, rq.size() - rq_base, 4);
        for (int k = 0; k < 4; k++)
            if (rq_base + k < rq.size()) begin
                chk({tag, "_re_cycle"}, rq[rq_base+k].cyc - c0, 1 + k * l);
                chk({tag, "_re_addr"}, rq[rq_base+k].a, a0 + k);
            end
    endtask

    initial begin
        logic [7:0] p3 [4];
        int dn;
        p3 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        rst_n = 1'b1; rw = '0; addr = '0; wdata = '0; mask = '0;
        pl_en = 1'b0; pl_a = '0; pl_d = '0;

        // Asynchronous reset: outputs clear before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_ctl", 32'({busy, done, re, we}), 0);
        chk("rst_ram_addr", 32'({raddr[1], raddr[0]}), 0);
        chk("rst_ram_wdata", 32'({rwd[1], rwd[0]}), 0);
        chk("rst_read_data", rdata[0] | rdata[1], 0);

        // Preload both RAMs while held in reset.
        @(negedge clk);
        pl_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pl_a = AW'(32'h100 + k); pl_d = 8'(8'h11 * (k + 1)); @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            pl_a = AW'(32'h200 + k); pl_d = 8'(8'h50 + k); @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            pl_a = AW'(32'h300 + k); pl_d = p3[k]; @(negedge clk);
        end
        pl_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Read with latency 1.
        drive(0, 2'b01, 32'h0000_0100, 0, 0, 1, 32'h44332211);
        wait_done(0, 6, 5, 1, "rd_l1");
        chk_rd_log("rd_l1", 1, 'h100);

        // Read with latency 3; upper address bits ignored.
        @(negedge clk);
        drive(1, 2'b01, 32'hF000_0100, 0, 0, 1, 32'h44332211);
        wait_done(1, 14, 13, 1, "rd_l3");
        chk_rd_log("rd_l3", 3, 'h100);

        // Masked write of lanes 1 and 3.
        @(negedge clk);
        drive(1, 2'b10, 32'h0000_0204, 32'hAABBCCDD, 4'b1010, 0, 0);
        wait_done(1, 3, 2, 0, "wr_1010");
        chk("wr_n_we", wq.size() - wq_base, 2);
        chk("wr_n_re", rq.size() - rq_base, 0);
        if (wq.size() - wq_base == 2) begin
            chk("wr_l1_cycle", wq[wq_base].cyc - c0, 1);
            chk("wr_l1_addr", wq[wq_base].a, 'h205);
            chk("wr_l1_data", wq[wq_base].d, 'hCC);
            chk("wr_l3_cycle", wq[wq_base+1].cyc - c0, 2);
            chk("wr_l3_addr", wq[wq_base+1].a, 'h207);
            chk("wr_l3_data", wq[wq_base+1].d, 'hAA);
        end
        chk("wr_keeps_read_data", rdata[1], 32'h44332211);

        // Read issued in the write's done cycle, then another in that read's done cycle.
        drive(1, 2'b01, 32'h0000_0204, 0, 0, 1, 32'hAA56CC54);
        wait_done(1, 14, 13, 1, "rd_after_wr");
        chk_rd_log("rd_after_wr", 3, 'h204);
        drive(1, 2'b01, 32'h0000_0300, 0, 0, 1, 32'hEFBEADDE);
        wait_done(1, 14, 13, 1, "rd_b2b");
        chk_rd_log("rd_b2b", 3, 'h300);

        // Empty write mask completes in cycle 1 with no RAM access.
        @(negedge clk);
        drive(1, 2'b10, 32'h0000_0208, 32'h12345678, 4'b0000, 0, 0);
        wait_done(1, 1, 0, 0, "wr_m0");
        chk("wr_m0_n_we", wq.size() - wq_base, 0);

        // Both flag bits: serviced as a read, never writes.
        @(negedge clk);
        drive(1, 2'b11, 32'h0000_0100, 32'hFFFFFFFF, 4'hF, 1, 32'h44332211);
        wait_done(1, 14, 13, 1, "rw11");
        chk("rw11_n_we", wq.size() - wq_base, 0);
        chk_rd_log("rw11", 3, 'h100);

        // Reset in cycle 3 of a read abandons it.
        @(negedge clk);
        drive(1, 2'b01, 32'h0000_0300, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_read_data", rdata[1] | rdata[0], 0);
        chk("midrst_ctl", 32'({busy, done, re, we}), 0);
        chk("midrst_ram_addr", 32'(raddr[1]), 0);
        dn = done_cnt[1];
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", done_cnt[1] - dn, 0);
        chk("midrst_idle", 32'({busy[1], re[1]}), 0);

        drive(1, 2'b01, 32'h0000_0200, 0, 0, 1, 32'h53525150);
        wait_done(1, 14, 13, 1, "rd_after_rst");
        chk_rd_log("rd_after_rst", 3, 'h200);

        chk("re_we_overlap", both_cnt, 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/byte_mem_ctrl.md
Name: byte_mem_ctrl

Overview:
- Sits directly downstream of the L1 cache. It takes the cache's word-wide memory request port and serves it from a byte-wide synchronous RAM (block RAM or external SRAM model).
- Each 32-bit read becomes four sequential byte reads. Each masked write becomes one byte write per enabled lane.
- `done` pulses once per transaction. A new request can be accepted in the same cycle `done` is high, which supports the cache's back-to-back line-fill requests.

Parameters:
- ADDR_WIDTH, 17: byte-address width of the RAM. Request address bits [31:ADDR_WIDTH] are ignored.
- RAM_LATENCY, 1: cycles from `ram_re` high to `ram_rdata` valid. Legal range 1..7.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- rw_flag  in  2  request from the cache; [0] read, [1] write; 0 means idle. Sampled only in IDLE.
- addr  in  32  word address of the request; bits [1:0] are ignored.
- write_data  in  32  write data, little-endian: lane k = [8k+7:8k].
- write_mask  in  4  byte-lane enables for a write.
- read_data  out  32  assembled read word.
- busy  out  1  high while a transaction is in progress.
- done  out  1  one-cycle completion pulse.
- ram_addr  out  ADDR_WIDTH  byte address to the RAM.
- ram_re  out  1  RAM read strobe.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  8  RAM write byte.
- ram_rdata  in  8  RAM read byte, valid RAM_LATENCY cycles after `ram_re`.

Behaviour:
- Reset (RST low, takes effect immediately, no clock needed):
  - state = IDLE; busy = 0; done = 0; ram_re = 0; ram_we = 0; ram_addr = 0; ram_wdata = 0; read_data = 0.
  - An in-flight transaction is abandoned. No `done` pulse is issued for it after reset releases.
- States: IDLE, READ, WRITE. Internal registers: latched address, data and mask; byte index [1:0]; latency counter [2:0].
- Cycle 0 is the cycle in which IDLE samples a nonzero `rw_flag`.
  - Request fields are latched at the end of cycle 0.
  - `busy` is high from cycle 1 until the final cycle of the transaction.
  - `rw_flag` is ignored outside IDLE.
- rw_flag priority: bit[0] wins, so 2'b11 is serviced as a read with `write_mask` ignored.
- Byte address for lane k = {addr[ADDR_WIDTH-1:2], k[1:0]}.
- READ:
  - Lanes are issued in order 0, 1, 2, 3.
  - Lane 0 is issued in cycle 1: ram_re = 1 and ram_addr = lane address.
  - Lane k's byte is captured into read_data[8k+7:8k] in cycle 1 + (k+1)·L, where L = RAM_LATENCY.
  - Lane k+1 is issued in the same cycle lane k is captured.
  - `ram_re` is low in all wait cycles.
  - After the lane-3 capture, the block returns to IDLE. In the next cycle (cycle 2 + 4L) done = 1, busy = 0, and read_data holds the full word.
  - read_data then holds its value until the next read overwrites it lane by lane.
- WRITE:
  - Only lanes with write_mask[k] = 1 are issued, in ascending order, one per cycle starting in cycle 1.
  - Each issued lane drives ram_we = 1, ram_addr = lane address, ram_wdata = write_data[8k+7:8k].
  - There is no latency wait. With N enabled lanes, done = 1 in cycle N + 1.
  - With write_mask = 0, no RAM access occurs and done = 1 in cycle 1.
  - read_data is unchanged by writes.
- Completion and back-to-back:
  - `done` is registered and coincides with state = IDLE.
  - A request presented in the `done` cycle is accepted; that cycle is its cycle 0.
  - `ram_re` and `ram_we` are never high in the same cycle.
- Counter wrap: the byte index wraps 3→0 only on return to IDLE. The latency counter reloads on every issue.

Test Plan:
- Read, L=1: RAM bytes at 0x100..0x103 = 11 22 33 44; rw_flag=1, addr=0x100 in cycle 0 → ram_re in cycles 1–4 at 0x100..0x103; done in cycle 6 with read_data = 0x44332211; busy high in cycles 1–5.
- Read, L=3: same data → issues in cycles 1, 4, 7, 10; done in cycle 14; read_data = 0x44332211.
- Masked write: addr=0x204, data=0xAABBCCDD, mask=4'b1010 → ram_we at 0x205 = CC (cycle 1) and 0x207 = AA (cycle 2); done in cycle 3; a follow-up read returns 0xAAxxCCxx with untouched lanes preserved. Mask 0 → no ram_we; done in cycle 1.
- Back-to-back: issue a new read in the `done` cycle of the previous read → accepted with no idle gap; its cycle 1 is the cycle after `done`; two distinct words are returned correctly.
- rw_flag=2'b11 with mask=4'hF → serviced as a read; ram_we is never asserted.
- Reset: drop RST in cycle 3 of a read → all outputs 0 immediately; after release, no `done` pulse occurs and a fresh read completes normally.
